pend_encoder: RTL and testbench
===============================

# pend_encoder

Sequential N-to-log2(N) encoder, the reverse of the register-file write-select decoder. It captures a request vector of N one-bit flags and emits the binary index of every set bit, lowest index first, one per accepted transfer on a valid/ready handshake. It sits between request/dirty-flag sources (e.g. register-file dirty bits) and any consumer that needs register numbers serialized onto a narrow bus.

## Interface
- N, 32, width of the request vector; power of two, 2..64.
- W, 5, index width; must equal log2(N).
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- load  input  1  request to capture `req`; honoured only while `busy`=0.
- req  input  N  request flags; bit i set means index i is to be emitted.
- busy  output  1  1 while a captured batch still has un-emitted bits.
- out_valid  output  1  `out_idx` holds a valid index.
- out_idx  output  W  binary index of the lowest pending set bit.
- out_ready  input  1  consumer accepts `out_idx` when `out_valid`=1 and `out_ready`=1.
- count  output  W+1  number of indices emitted in the current or most recent batch.
- done  output  1  one-cycle pulse when a batch completes.

## Operation
- Internal state: pending register P[N-1:0], and a two-state FSM with states IDLE and EMIT.
- Reset (async, reset=0): P=0, state=IDLE. All outputs are 0: busy, out_valid, out_idx, count, done.
- IDLE, load=1, req≠0: P←req, count←0, state→EMIT. out_valid←1. out_idx←index of the lowest set bit of req.
- IDLE, load=1, req=0: P stays 0, count←0, state stays IDLE, and done pulses high on the next cycle (empty batch).
- IDLE, load=0: hold all state. done←0.
- EMIT: busy=1. load is ignored entirely, so `req` is not sampled.
- EMIT, transfer (out_valid & out_ready): clear bit out_idx in P and increment count.
  - If other bits remain, out_idx←lowest remaining set bit and out_valid stays 1.
  - If no bits remain, state→IDLE, out_valid←0, and done pulses for one cycle.
- EMIT, out_valid=1 and out_ready=0: out_idx, P and count hold stable. Valid is never withdrawn without a transfer.
- busy = (state==EMIT). It is registered, so it falls together with out_valid.
- count saturates at neither end in practice: its maximum is N, which is why it is W+1 bits wide. It holds its value in IDLE until the next accepted load.
- Index selection is strictly the lowest set bit of P. Bit N-1 must encode to all-ones (N-1).

## Timing
- out_valid, out_idx, busy, count and done are all registered outputs with no combinational path from inputs.
- Load accepted at edge k: out_valid=1 and the first index are visible after edge k.
- With out_ready held high, the block sustains one index per cycle. A batch of B set bits finishes in B cycles after capture.
- done is high for exactly the cycle following the edge of the final transfer, or following the capturing edge for an empty batch.
- A new load can be accepted in the same cycle that done is high, since state is IDLE by then.
- Reset asserted mid-batch discards P immediately, and outputs go to 0 without waiting for a clock edge. After reset deasserts, the block needs a fresh load.

## Test plan
- Reset: hold reset=0 with load=1 and req=32'hFFFF_FFFF. Required: all outputs 0, no capture. Release reset: outputs stay 0 until load.
- Batch with ready high: load req=32'h8000_0011, out_ready=1. Required: out_idx sequence 0, 4, 31 on three consecutive cycles, count ends at 3, done pulses once, busy drops with out_valid.
- Backpressure: load req=32'h0000_0006, out_ready=0 for 4 cycles, then 1. Required: out_idx=1 stable with out_valid=1 throughout the stall, then 1 and 2 emitted, count=2.
- Load while busy: during a batch from req=32'h0000_00F0, pulse load with req=32'h0000_0001. Required: ignored; only indices 4, 5, 6, 7 are emitted.
- Empty batch: load req=0. Required: busy and out_valid stay 0, count=0, and done is high for exactly one cycle.
- Reset mid-batch: load req=32'hFFFF_FFFF and emit 3 indices, then pulse reset=0 between edges. Required: out_valid, busy and count go to 0 asynchronously, and no further indices are emitted.

Source files
------------

// File: rtl/pend_encoder_if.sv
// Handshake bundle between a request source/consumer and pend_encoder.
// The master side loads request vectors and consumes indices; the slave
// side is the encoder itself.
interface pend_encoder_if #(
    parameter int N = 32,
    parameter int W = 5
);
    logic         load;
    logic [N-1:0] req;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         out_ready;
    logic [W:0]   count;
    logic         done;

    modport master (
        output load,
        output req,
        output out_ready,
        input  busy,
        input  out_valid,
        input  out_idx,
        input  count,
        input  done
    );

    modport slave (
        input  load,
        input  req,
        input  out_ready,
        output busy,
        output out_valid,
        output out_idx,
        output count,
        output done
    );
endinterface

// File: rtl/pend_encoder.sv
// Sequential N-to-log2(N) encoder: captures a request vector and emits the
// index of each set bit, lowest first, one per accepted valid/ready transfer.
// All outputs come straight from flops.
module pend_encoder #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic           clk,
    input  logic           reset,
    pend_encoder_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state, state_n;
    logic [N-1:0] pend, pend_n, pend_clr;
    logic [W-1:0] idx, idx_n;
    logic [W:0]   cnt, cnt_n;
    logic         done_q, done_n;
    logic         xfer;

    // Index of the lowest set bit; scanning downward lets the lowest hit win.
    function automatic logic [W-1:0] lowest(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (v[i-1]) r = W'(i - 1);
        end
        return r;
    endfunction

    assign xfer = (state == EMIT) && bus.out_ready;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and next-datapath values; load is only looked at in IDLE.
    always_comb begin
        state_n  = state;
        pend_n   = pend;
        idx_n    = idx;
        cnt_n    = cnt;
        done_n   = 1'b0;
        pend_clr = pend;
        pend_clr[idx] = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.load) begin
                    pend_n = bus.req;
                    cnt_n  = '0;
                    if (bus.req != '0) begin
                        state_n = EMIT;
                        idx_n   = lowest(bus.req);
                    end else begin
                        done_n  = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (xfer) begin
                    pend_n = pend_clr;
                    cnt_n  = cnt + 1'b1;
                    if (pend_clr != '0) begin
                        idx_n   = lowest(pend_clr);
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath registers: pending flags, current index, emit count, done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend   <= '0;
            idx    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            pend   <= pend_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            done_q <= done_n;
        end
    end

    // busy and out_valid are both the decoded state flop, so they fall together.
    assign bus.busy      = (state == EMIT);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_idx   = idx;
    assign bus.count     = cnt;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_pend_encoder.sv
// Directed bench for pend_encoder: a table of ready-high batches plus
// hand-written sequences for reset, backpressure, load-while-busy, empty
// batch and reset mid-batch.
module tb_pend_encoder;

    localparam int N = 32;
    localparam int W = 5;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    pend_encoder_if #(.N(N), .W(W)) ifc ();

    pend_encoder #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        string        tag;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},      64'(ifc.busy),      64'd0);
        chk({tag, ".out_valid"}, 64'(ifc.out_valid), 64'd0);
        chk({tag, ".out_idx"},   64'(ifc.out_idx),   64'd0);
        chk({tag, ".count"},     64'(ifc.count),     64'd0);
        chk({tag, ".done"},      64'(ifc.done),      64'd0);
    endtask

    // Load r with ready high and follow the batch to its done cycle.
    // Returns in the done cycle so the next load can start right there.
    task automatic run_batch(input logic [N-1:0] r, input string tag);
        int q[$];
        for (int i = 0; i < N; i++) if (r[i]) q.push_back(i);
        ifc.req       = r;
        ifc.load      = 1'b1;
        ifc.out_ready = 1'b1;
        tick();
        ifc.load = 1'b0;
        ifc.req  = '0;
        if (q.size() == 0) begin
            chk({tag, ".empty_done"},  64'(ifc.done),      64'd1);
            chk({tag, ".empty_busy"},  64'(ifc.busy),      64'd0);
            chk({tag, ".empty_valid"}, 64'(ifc.out_valid), 64'd0);
            chk({tag, ".empty_count"}, 64'(ifc.count),     64'd0);
            return;
        end
        for (int j = 0; j < q.size(); j++) begin
            chk({tag, ".valid"}, 64'(ifc.out_valid), 64'd1);
            chk({tag, ".busy"},  64'(ifc.busy),      64'd1);
            chk({tag, ".idx"},   64'(ifc.out_idx),   64'(q[j]));
            chk({tag, ".count"}, 64'(ifc.count),     64'(j));
            chk({tag, ".done_low"}, 64'(ifc.done),   64'd0);
            tick();
        end
        chk({tag, ".end_valid"}, 64'(ifc.out_valid), 64'd0);
        chk({tag, ".end_busy"},  64'(ifc.busy),      64'd0);
        chk({tag, ".end_done"},  64'(ifc.done),      64'd1);
        chk({tag, ".end_count"}, 64'(ifc.count),     64'(q.size()));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{req: 32'h8000_0011, tag: "ready_hi"};
        vecs[1] = '{req: 32'h0000_0001, tag: "bit0"};
        vecs[2] = '{req: 32'h8000_0000, tag: "bit31"};
        vecs[3] = '{req: 32'h0000_00A5, tag: "a5"};
        vecs[4] = '{req: 32'hFFFF_FFFF, tag: "all"};
        vecs[5] = '{req: 32'h4000_0002, tag: "sparse"};

        // Reset held with load and a full request: nothing may be captured.
        reset         = 1'b0;
        ifc.load      = 1'b1;
        ifc.req       = '1;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        chk_all_zero("rst_hold");
        ifc.load = 1'b0;
        ifc.req  = '0;
        reset    = 1'b1;
        tick();
        tick();
        tick();
        chk_all_zero("rst_release");

        // Table of ready-high batches, each loaded in the previous done cycle.
        for (int v = 0; v < $size(vecs); v++) run_batch(vecs[v].req, vecs[v].tag);
        tick();
        chk("done_single", 64'(ifc.done), 64'd0);

        // Backpressure: index 1 must hold through a 4-cycle stall.
        ifc.req       = 32'h0000_0006;
        ifc.load      = 1'b1;
        ifc.out_ready = 1'b0;
        tick();
        ifc.load = 1'b0;
        ifc.req  = '0;
        for (int s = 0; s < 4; s++) begin
            chk("bp.valid", 64'(ifc.out_valid), 64'd1);
            chk("bp.idx",   64'(ifc.out_idx),   64'd1);
            chk("bp.count", 64'(ifc.count),     64'd0);
            tick();
        end
        ifc.out_ready = 1'b1;
        chk("bp.idx_a", 64'(ifc.out_idx), 64'd1);
        tick();
        chk("bp.idx_b", 64'(ifc.out_idx), 64'd2);
        chk("bp.valid_b", 64'(ifc.out_valid), 64'd1);
        tick();
        chk("bp.end_valid", 64'(ifc.out_valid), 64'd0);
        chk("bp.count_end", 64'(ifc.count), 64'd2);
        chk("bp.done", 64'(ifc.done), 64'd1);
        tick();

        // Load while busy must be ignored.
        ifc.req  = 32'h0000_00F0;
        ifc.load = 1'b1;
        tick();
        ifc.req  = 32'h0000_0001;
        ifc.load = 1'b1;
        for (int k = 4; k < 8; k++) begin
            chk("lwb.valid", 64'(ifc.out_valid), 64'd1);
            chk("lwb.idx",   64'(ifc.out_idx),   64'(k));
            tick();
            ifc.load = 1'b0;
            ifc.req  = '0;
        end
        chk("lwb.end_valid", 64'(ifc.out_valid), 64'd0);
        chk("lwb.count", 64'(ifc.count), 64'd4);
        chk("lwb.done", 64'(ifc.done), 64'd1);
        tick();
        chk("lwb.no_more", 64'(ifc.out_valid), 64'd0);

        // Empty batch: count clears from 4 to 0 and done pulses once.
        run_batch('0, "empty");
        tick();
        chk("empty.done_drop", 64'(ifc.done), 64'd0);
        chk("empty.valid", 64'(ifc.out_valid), 64'd0);

        // Reset mid-batch, asserted between clock edges.
        run_batch_prefix();
        #3;
        reset = 1'b0;
        #1;
        chk("mid.valid", 64'(ifc.out_valid), 64'd0);
        chk("mid.busy",  64'(ifc.busy),      64'd0);
        chk("mid.count", 64'(ifc.count),     64'd0);
        chk("mid.idx",   64'(ifc.out_idx),   64'd0);
        #2;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid.after_valid", 64'(ifc.out_valid), 64'd0);
        end
        chk("mid.after_count", 64'(ifc.count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Load all ones and let three indices go, stopping with index 3 pending.
    task automatic run_batch_prefix();
        ifc.req       = '1;
        ifc.load      = 1'b1;
        ifc.out_ready = 1'b1;
        tick();
        ifc.load = 1'b0;
        ifc.req  = '0;
        tick();
        tick();
        tick();
        chk("mid.pre_idx",   64'(ifc.out_idx), 64'd3);
        chk("mid.pre_count", 64'(ifc.count),   64'd3);
    endtask

endmodule
